// File: rtl/matrix_add_sequencer.sv
// Sequences one matrix-addition command: streams A and B from a byte RAM into the adder
// operand registers, captures the sum and overflow, writes the result back and pulses done.
module matrix_add_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        matrix_size,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_r,
  output logic              busy,
  output logic              done,
  output logic              overflow_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic [199:0]      add_a,
  output logic [199:0]      add_b,
  output logic [1:0]        add_size,
  input  logic [199:0]      add_result,
  input  logic              add_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_EXEC, S_STORE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         size_q, size_d;
  logic [ADDR_W-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, base_r_q, base_r_d;
  logic [24:0][7:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;

  logic [5:0]         n_elems;
  logic [5:0]         cnt_nxt;
  logic [5:0]         idx;

  always_comb begin
    n_elems = 6'd4;
    unique case (size_q)
      2'b00: n_elems = 6'd4;
      2'b01: n_elems = 6'd9;
      2'b10: n_elems = 6'd16;
      2'b11: n_elems = 6'd25;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or an explicit idle value) so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_r_d = base_r_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_nxt  = cnt_q + 6'd1;
    idx      = cnt_q - 6'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          size_d   = matrix_size;
          base_a_d = base_a;
          base_b_d = base_b;
          base_r_d = base_r;
          opa_d    = '0;
          opb_d    = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          rd_en_d  = 1'b1;
          addr_d   = base_a;
          cnt_d    = 6'd0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // Read data lags the strobe by one cycle, so this cycle lands the byte from cnt-1.
        if (cnt_q != 6'd0) begin
          if (idx < n_elems) opa_d[5'(idx)] = mem_rdata;
          else               opb_d[5'(idx - n_elems)] = mem_rdata;
        end
        if (cnt_q == 6'((n_elems << 1) - 6'd1)) begin
          rd_en_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt < n_elems) addr_d = base_a_q + ADDR_W'(cnt_nxt);
          else                   addr_d = base_b_q + ADDR_W'(cnt_nxt - n_elems);
        end
      end
      S_DRAIN: begin
        opb_d[5'(n_elems - 6'd1)] = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = add_result;
        ovf_d   = add_overflow;
        wr_en_d = 1'b1;
        addr_d  = base_r_q;
        wdata_d = add_result[7:0];
        cnt_d   = 6'd0;
        state_d = S_STORE;
      end
      S_STORE: begin
        if (cnt_q == n_elems - 6'd1) begin
          wr_en_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_nxt;
          addr_d  = base_r_q + ADDR_W'(cnt_nxt);
          wdata_d = res_q[5'(cnt_nxt)];
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      // NOTE: the result array is ordinary flops, not a RAM, so it is cleared with everything else.
      res_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_r_q <= base_r_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow_flag = ovf_q;
  assign mem_addr      = addr_q;
  assign mem_rd_en     = rd_en_q;
  assign mem_wr_en     = wr_en_q;
  assign mem_wdata     = wdata_q;
  assign add_a         = opa_q;
  assign add_b         = opb_q;
  assign add_size      = size_q;

endmodule

// File: tb/tb_matrix_add_sequencer.sv
// Scoreboard bench for matrix_add_sequencer: byte RAM and signed adder models, expected
// reads/writes/done events queued at issue time and compared by an independent monitor.
module tb_matrix_add_sequencer;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   matrix_size;
  logic [7:0]   base_a, base_b, base_r;
  logic         busy, done, overflow_flag;
  logic [7:0]   mem_addr, mem_rdata, mem_wdata;
  logic         mem_rd_en, mem_wr_en;
  logic [199:0] add_a, add_b, add_result;
  logic [1:0]   add_size;
  logic         add_overflow;

  logic         host_we;
  logic [7:0]   host_addr, host_data;
  logic [7:0]   ram [256];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct {
    int           e0;
    int           cycle;
    logic         ovf;
    logic [199:0] a;
    logic [199:0] b;
    logic [1:0]   size;
  } done_t;

  logic [7:0] exp_rd [$];
  wr_t        exp_wr [$];
  done_t      exp_done [$];

  matrix_add_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .base_a(base_a), .base_b(base_b), .base_r(base_r),
    .busy(busy), .done(done), .overflow_flag(overflow_flag),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .add_a(add_a), .add_b(add_b), .add_size(add_size),
    .add_result(add_result), .add_overflow(add_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (host_we)        ram[host_addr] <= host_data;
    else if (mem_wr_en) ram[mem_addr]  <= mem_wdata;
    if (mem_rd_en)      mem_rdata      <= ram[mem_addr];
  end

  // Signed element-wise adder over the active N elements.
  always_comb begin
    int n, s;
    add_result   = '0;
    add_overflow = 1'b0;
    n = (int'(add_size) + 2) * (int'(add_size) + 2);
    for (int i = 0; i < 25; i++) begin
      if (i < n) begin
        s = int'($signed(add_a[i*8 +: 8])) + int'($signed(add_b[i*8 +: 8]));
        add_result[i*8 +: 8] = 8'(s);
        if (s > 127 || s < -128) add_overflow = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents traffic or a done pulse.
  always @(negedge clk) begin
    done_t d;
    if (mem_rd_en || mem_wr_en) check("rd_wr_exclusive", mem_rd_en & mem_wr_en, 0);
    if (mem_rd_en) begin
      if (exp_rd.size() == 0) fail("extra_read");
      else check("read_addr", mem_addr, exp_rd.pop_front());
    end
    if (mem_wr_en) begin
      if (exp_wr.size() == 0) fail("extra_write");
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("write_addr", mem_addr, w.addr);
        check("write_data", mem_wdata, w.data);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) fail("extra_done");
      else begin
        d = exp_done.pop_front();
        check("done_cycle", cyc - d.e0 + 1, d.cycle);
        check("done_overflow", overflow_flag, d.ovf);
        check("done_add_a", add_a, d.a);
        check("done_add_b", add_b, d.b);
        check("done_add_size", add_size, d.size);
        check("done_busy", busy, 1);
      end
    end
  end

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    host_we = 1'b1; host_addr = addr; host_data = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Loads operands into RAM, queues the expected traffic, then pulses start for one cycle.
  task automatic issue(input logic [1:0] sz, input logic [7:0] ba, input logic [7:0] bb,
                       input logic [7:0] br, input logic [7:0] a [25], input logic [7:0] b [25],
                       input int keep_wr, input bit want_done);
    int    n, s;
    done_t d;
    wr_t   w;
    n = (int'(sz) + 2) * (int'(sz) + 2);
    d.a = '0; d.b = '0; d.ovf = 1'b0; d.size = sz; d.cycle = 3 * n + 3;
    for (int k = 0; k < n; k++) poke(ba + 8'(k), a[k]);
    for (int k = 0; k < n; k++) poke(bb + 8'(k), b[k]);
    for (int k = 0; k < n; k++) exp_rd.push_back(ba + 8'(k));
    for (int k = 0; k < n; k++) exp_rd.push_back(bb + 8'(k));
    for (int k = 0; k < n; k++) begin
      s = int'($signed(a[k])) + int'($signed(b[k]));
      if (s > 127 || s < -128) d.ovf = 1'b1;
      d.a[k*8 +: 8] = a[k];
      d.b[k*8 +: 8] = b[k];
      w.addr = br + 8'(k);
      w.data = 8'(s);
      if (k < keep_wr) exp_wr.push_back(w);
    end
    matrix_size = sz; base_a = ba; base_b = bb; base_r = br; start = 1'b1;
    d.e0 = cyc + 1;
    if (want_done) exp_done.push_back(d);
    @(negedge clk);
    start = 1'b0;
    matrix_size = 2'($urandom); base_a = 8'($urandom); base_b = 8'($urandom);
    base_r = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("wait_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a [25];
    logic [7:0] b [25];
    logic [7:0] ba, bb, br;
    rst = 1'b1; start = 1'b0; matrix_size = '0; base_a = '0; base_b = '0; base_r = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow_flag, 0);
    check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    check("rst_operands", {add_a, add_b} != 0, 0);
    check("rst_size", add_size, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 basic sum
    foreach (a[i]) begin a[i] = 8'd0; b[i] = 8'd0; end
    a[0] = 8'd1;  a[1] = 8'd2;  a[2] = 8'd3;  a[3] = 8'd4;
    b[0] = 8'd10; b[1] = 8'd20; b[2] = 8'd30; b[3] = 8'd40;
    issue(2'b00, 8'h10, 8'h20, 8'h30, a, b, 25, 1'b1);
    wait_idle();
    check("t2x2_r0", ram[8'h30], 8'd11);
    check("t2x2_r1", ram[8'h31], 8'd22);
    check("t2x2_r2", ram[8'h32], 8'd33);
    check("t2x2_r3", ram[8'h33], 8'd44);
    check("t2x2_ovf", overflow_flag, 0);

    // 5x5 overflow in the last element
    foreach (a[i]) begin a[i] = 8'd0; b[i] = 8'd0; end
    a[24] = 8'd127; b[24] = 8'd1;
    issue(2'b11, 8'h00, 8'h40, 8'h80, a, b, 25, 1'b1);
    wait_idle();
    check("t5x5_r24", ram[8'h98], 8'h80);
    check("t5x5_ovf", overflow_flag, 1);

    // negative operands
    foreach (a[i]) begin a[i] = 8'd0; b[i] = 8'd0; end
    a[0] = 8'h80; b[0] = 8'hFF;
    issue(2'b01, 8'h50, 8'h60, 8'h70, a, b, 25, 1'b1);
    wait_idle();
    check("tneg_r0", ram[8'h70], 8'h7F);
    check("tneg_ovf", overflow_flag, 1);
    a[0] = 8'hFB; b[0] = 8'h03;
    issue(2'b01, 8'h50, 8'h60, 8'h70, a, b, 25, 1'b1);
    wait_idle();
    check("tneg2_r0", ram[8'h70], 8'hFE);
    check("tneg2_ovf", overflow_flag, 0);

    // zeroing of unused elements after a larger command
    foreach (a[i]) begin a[i] = 8'h11; b[i] = 8'h11; end
    issue(2'b11, 8'h00, 8'h40, 8'h80, a, b, 25, 1'b1);
    wait_idle();
    foreach (a[i]) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
    issue(2'b01, 8'h00, 8'h40, 8'h80, a, b, 25, 1'b1);
    wait_idle();
    check("tzero_a_hi", add_a[199:72], 0);
    check("tzero_b_hi", add_b[199:72], 0);

    // start while busy (in LOAD and in the DONE cycle) is ignored
    issue(2'b00, 8'h10, 8'h20, 8'h30, a, b, 25, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("tign_done_seen", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("tign_busy", busy, 0);

    // reset in the third STORE cycle
    foreach (a[i]) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
    issue(2'b01, 8'h90, 8'hA0, 8'hB0, a, b, 3, 1'b0);
    repeat (2 * 9 + 4) @(negedge clk);
    check("trst_in_store", mem_wr_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("trst_busy", busy, 0);
    check("trst_strobes", {mem_rd_en, mem_wr_en, done}, 0);
    check("trst_ovf", overflow_flag, 0);
    check("trst_operands", {add_a, add_b} != 0, 0);
    repeat (4) @(negedge clk);
    check("trst_writes_left", exp_wr.size(), 0);
    issue(2'b01, 8'h90, 8'hA0, 8'hB0, a, b, 25, 1'b1);
    wait_idle();

    // address wrap
    issue(2'b00, 8'hFE, 8'h10, 8'h20, a, b, 25, 1'b1);
    wait_idle();

    // randomized commands
    for (int t = 0; t < 12; t++) begin
      ba = 8'($urandom);
      bb = ba + 8'd25 + 8'($urandom_range(0, 60));
      br = 8'($urandom);
      foreach (a[i]) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
      issue(2'($urandom_range(0, 3)), ba, bb, br, a, b, 25, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("end_reads_left", exp_rd.size(), 0);
    check("end_writes_left", exp_wr.size(), 0);
    check("end_dones_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
